// File: rtl/xy_pkg.sv
// Shared types and constants for the xy_filter blob-coordinate conditioner.
package xy_pkg;

    localparam int unsigned COORD_W = 11;
    localparam logic [COORD_W-1:0] NO_BLOB = 11'd1023;

    typedef enum logic [0:0] {
        StIdle,
        StTrack
    } state_e;

    // Magnitude of a - b, computed in 12-bit signed arithmetic.
    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        logic signed [COORD_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

endpackage

// File: rtl/xy_filter_if.sv
// Camera-sample input and filtered-position output bundle for xy_filter.
interface xy_filter_if;
    import xy_pkg::*;

    logic               raw_valid;
    logic [COORD_W-1:0] raw_x;
    logic [COORD_W-1:0] raw_y;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               out_valid;
    logic               tracking;

    modport master (
        output raw_valid, raw_x, raw_y,
        input  x, y, out_valid, tracking
    );

    modport slave (
        input  raw_valid, raw_x, raw_y,
        output x, y, out_valid, tracking
    );

endinterface

// File: rtl/xy_avg_window.sv
// Per-axis moving-average window: ring buffer, write pointer and running sum.
module xy_avg_window
    import xy_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               preload,
    input  logic               push,
    input  logic [COORD_W-1:0] din,
    output logic [COORD_W-1:0] mean
);

    localparam int unsigned Depth = 1 << AVG_LOG2;
    localparam int unsigned PtrW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SumW  = COORD_W + AVG_LOG2;

    logic [COORD_W-1:0] ring_q [Depth];
    logic [PtrW-1:0]    ptr_q;
    logic [PtrW-1:0]    ptr_next;
    logic [SumW-1:0]    sum_q;

    assign ptr_next = (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + PtrW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(Depth); i++) ring_q[i] <= '0;
            ptr_q <= '0;
            sum_q <= '0;
        end else if (preload) begin
            for (int i = 0; i < int'(Depth); i++) ring_q[i] <= din;
            ptr_q <= '0;
            sum_q <= SumW'(din) << AVG_LOG2;
        end else if (push) begin
            // The oldest slot is always part of the sum, so the subtraction never wraps.
            ring_q[ptr_q] <= din;
            ptr_q         <= ptr_next;
            sum_q         <= sum_q + SumW'(din) - SumW'(ring_q[ptr_q]);
        end
    end

    assign mean = COORD_W'(sum_q >> AVG_LOG2);

endmodule

// File: rtl/xy_filter.sv
// Blob coordinate filter: miss rejection, moving average, lost-track detection.
// Optional outlier rejection is enabled with `define XY_FILTER_OUTLIER_EN.
module xy_filter
    import xy_pkg::*;
#(
    parameter int unsigned AVG_LOG2     = 2,
    parameter int unsigned LOST_SAMPLES = 4,
    parameter int unsigned MAX_JUMP     = 200
) (
    input logic        clk,
    input logic        reset,
    xy_filter_if.slave bus
);

    if (AVG_LOG2 > 4 || LOST_SAMPLES < 1 || LOST_SAMPLES > 255 || MAX_JUMP > 2047) begin : g_bad_param
        $error("xy_filter: parameter out of range");
    end

    state_e             state_q, state_d;
    logic [7:0]         miss_cnt_q, miss_cnt_d;
    logic               upd_q;
    logic [COORD_W-1:0] x_q, y_q;
    logic               out_valid_q, tracking_q, tracking_d;
    logic               is_blob, is_miss, is_jump;
    logic               preload, push, accept, drop;
    logic [COORD_W-1:0] mean_x, mean_y;

    assign is_blob = bus.raw_valid && (bus.raw_x != NO_BLOB) && (bus.raw_y != NO_BLOB);
    assign is_miss = bus.raw_valid && !is_blob;

`ifdef XY_FILTER_OUTLIER_EN
    assign is_jump = is_blob && ((abs_diff(bus.raw_x, x_q) > (COORD_W + 1)'(MAX_JUMP)) ||
                                 (abs_diff(bus.raw_y, y_q) > (COORD_W + 1)'(MAX_JUMP)));
`else
    assign is_jump = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        miss_cnt_d = miss_cnt_q;
        preload    = 1'b0;
        push       = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_blob) begin
                    preload    = 1'b1;
                    accept     = 1'b1;
                    miss_cnt_d = '0;
                    state_d    = StTrack;
                end
            end
            StTrack: begin
                if (is_blob && !is_jump) begin
                    push       = 1'b1;
                    accept     = 1'b1;
                    miss_cnt_d = '0;
                end else if (is_miss || is_jump) begin
                    if (miss_cnt_q == 8'(LOST_SAMPLES - 1)) begin
                        miss_cnt_d = '0;
                        drop       = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Entering IDLE wins over a rise from a still-pending update.
    always_comb begin
        tracking_d = tracking_q;
        if (upd_q) tracking_d = 1'b1;
        if (drop)  tracking_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            miss_cnt_q  <= '0;
            upd_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            tracking_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_cnt_q  <= miss_cnt_d;
            upd_q       <= accept;
            out_valid_q <= upd_q;
            tracking_q  <= tracking_d;
            if (upd_q) begin
                x_q <= mean_x;
                y_q <= mean_y;
            end
        end
    end

    xy_avg_window #(.AVG_LOG2(AVG_LOG2)) u_win_x (
        .clk     (clk),
        .reset   (reset),
        .preload (preload),
        .push    (push),
        .din     (bus.raw_x),
        .mean    (mean_x)
    );

    xy_avg_window #(.AVG_LOG2(AVG_LOG2)) u_win_y (
        .clk     (clk),
        .reset   (reset),
        .preload (preload),
        .push    (push),
        .din     (bus.raw_y),
        .mean    (mean_y)
    );

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.tracking  = tracking_q;

endmodule

// File: tb/tb_xy_filter.sv
// Directed plus randomized bench for xy_filter against a queue-based reference model.
module tb_xy_filter;

    localparam int unsigned AVG_LOG2 = 2;
    localparam int          LOST     = 4;
    localparam int          MAX_JUMP = 200;
    localparam int          N        = 1 << AVG_LOG2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    xy_filter_if bus ();

    xy_filter #(
        .AVG_LOG2     (AVG_LOG2),
        .LOST_SAMPLES (LOST),
        .MAX_JUMP     (MAX_JUMP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: window as a queue of the last N accepted samples.
    int qx[$];
    int qy[$];
    bit m_acq;
    int m_miss;
    int m_x, m_y, m_px, m_py;
    bit m_ov, m_trk, m_pend;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > 2046) return 2046;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit v, input int rx, input int ry);
        int old_x, old_y;
        bit blob, bad;
        if (!rst) begin
            qx.delete();
            qy.delete();
            m_acq = 0; m_miss = 0; m_x = 0; m_y = 0;
            m_ov = 0; m_trk = 0; m_pend = 0;
            return;
        end
        old_x = m_x;
        old_y = m_y;
        m_ov  = m_pend;
        if (m_pend) begin
            m_x   = m_px;
            m_y   = m_py;
            m_trk = 1;
        end
        m_pend = 0;
        blob = v && (rx != 1023) && (ry != 1023);
        if (!v) return;
        if (!m_acq) begin
            if (blob) begin
                qx.delete();
                qy.delete();
                repeat (N) begin
                    qx.push_back(rx);
                    qy.push_back(ry);
                end
                m_acq = 1; m_miss = 0; m_pend = 1;
                m_px = rx; m_py = ry;
            end
        end else begin
            bad = !blob;
`ifdef XY_FILTER_OUTLIER_EN
            if (blob && (iabs(rx - old_x) > MAX_JUMP || iabs(ry - old_y) > MAX_JUMP)) bad = 1;
`endif
            if (!bad) begin
                void'(qx.pop_front());
                void'(qy.pop_front());
                qx.push_back(rx);
                qy.push_back(ry);
                m_miss = 0;
                m_pend = 1;
                m_px = qx.sum() / N;
                m_py = qy.sum() / N;
            end else begin
                m_miss++;
                if (m_miss == LOST) begin
                    m_acq = 0; m_miss = 0; m_trk = 0;
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit v, input int rx, input int ry);
        @(negedge clk);
        reset         = rst;
        bus.raw_valid = v;
        bus.raw_x     = 11'(rx);
        bus.raw_y     = 11'(ry);
        @(posedge clk);
        #1;
        model_step(rst, v, rx, ry);
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("x",         32'(bus.x),         32'(m_x));
        check("y",         32'(bus.y),         32'(m_y));
        check("tracking",  32'(bus.tracking),  32'(m_trk));
    endtask

    initial begin
        int cx, cy, r, rx, ry;
        bit v, rst;

        reset         = 1'b0;
        bus.raw_valid = 1'b0;
        bus.raw_x     = '0;
        bus.raw_y     = '0;

        step(0, 0, 0, 0);
        step(0, 1, 100, 100);
        check("rst_x",   32'(bus.x), 32'd0);
        check("rst_trk", 32'(bus.tracking), 32'd0);

        // Acquire and smoothing.
        step(1, 1, 600, 300);
        check("lat_ov", 32'(bus.out_valid), 32'd0);
        step(1, 1, 604, 300);
        check("acq_x",  32'(bus.x), 32'd600);
        check("acq_y",  32'(bus.y), 32'd300);
        check("acq_ov", 32'(bus.out_valid), 32'd1);
        check("acq_trk", 32'(bus.tracking), 32'd1);
        step(1, 1, 608, 300);
        check("avg1", 32'(bus.x), 32'd601);
        step(1, 1, 612, 300);
        check("avg2", 32'(bus.x), 32'd603);
        step(1, 0, 0, 0);
        check("avg3", 32'(bus.x), 32'd606);

        // Lost after four misses.
        repeat (3) step(1, 1, 1023, 1023);
        check("miss3_trk", 32'(bus.tracking), 32'd1);
        step(1, 1, 1023, 1023);
        check("lost_trk", 32'(bus.tracking), 32'd0);
        check("lost_x",   32'(bus.x), 32'd606);
        check("lost_ov",  32'(bus.out_valid), 32'd0);

        // Reacquire at (500,500); a 3-miss run keeps tracking.
        step(1, 1, 500, 500);
        step(1, 0, 0, 0);
        check("reacq_x", 32'(bus.x), 32'd500);
        repeat (3) step(1, 1, 1023, 400);
        step(1, 1, 500, 500);
        step(1, 0, 0, 0);
        check("run3_trk", 32'(bus.tracking), 32'd1);

        // Large jump.
        step(1, 1, 900, 500);
        step(1, 0, 0, 0);
`ifdef XY_FILTER_OUTLIER_EN
        check("jump_ov", 32'(bus.out_valid), 32'd0);
        check("jump_x",  32'(bus.x), 32'd500);
`else
        check("jump_ov", 32'(bus.out_valid), 32'd1);
        check("jump_x",  32'(bus.x), 32'd600);
`endif

        // Reset beats a simultaneous blob.
        step(0, 1, 700, 700);
        check("rstblob_x",   32'(bus.x), 32'd0);
        check("rstblob_y",   32'(bus.y), 32'd0);
        check("rstblob_ov",  32'(bus.out_valid), 32'd0);
        check("rstblob_trk", 32'(bus.tracking), 32'd0);
        step(1, 1, 650, 640);
        step(1, 0, 0, 0);
        check("post_x", 32'(bus.x), 32'd650);
        check("post_y", 32'(bus.y), 32'd640);

        // Idle inputs toggling with raw_valid low.
        for (int i = 0; i < 20; i++) begin
            step(1, 0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
            check("hold_x",   32'(bus.x), 32'd650);
            check("hold_y",   32'(bus.y), 32'd640);
            check("hold_ov",  32'(bus.out_valid), 32'd0);
            check("hold_trk", 32'(bus.tracking), 32'd1);
        end

        // Randomized random-walk with misses, jumps and occasional resets.
        cx = 800;
        cy = 400;
        for (int i = 0; i < 400; i++) begin
            r   = int'($urandom_range(0, 99));
            rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            v   = ($urandom_range(0, 99) < 75);
            if (r < 12) begin
                rx = 1023;
                ry = ($urandom_range(0, 1) != 0) ? 1023 : cy;
            end else if (r < 22) begin
                cx = int'($urandom_range(0, 2046));
                cy = int'($urandom_range(0, 2046));
                rx = cx;
                ry = cy;
            end else begin
                cx = clamp(cx + int'($urandom_range(0, 300)) - 150);
                cy = clamp(cy + int'($urandom_range(0, 300)) - 150);
                rx = cx;
                ry = cy;
            end
            step(rst, v, rx, ry);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
